bcd_addsub_seq: RTL
===================

Name: bcd_addsub_seq

Overview:
Digit-serial N-digit packed-BCD adder/subtractor with a start/busy/done handshake. It processes one BCD digit per clock, least-significant digit first, using a single corrected digit adder. Add mode computes a+b+cin. Subtract mode computes a−b−cin using nine's complement. It replaces the single-digit combinational BCD adder wherever multi-digit operands or subtraction are needed.

Parameters:
DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE or DONE
mode  in  1  0 = add, 1 = subtract; sampled with start
a  in  4*DIGITS  packed BCD operand; digit 0 is in bits [3:0]; sampled with start
b  in  4*DIGITS  packed BCD operand; sampled with start
cin  in  1  carry-in (add) or borrow-in (sub); sampled with start
busy  out  1  high in RUN
done  out  1  one-cycle pulse in DONE
sum  out  4*DIGITS  packed BCD result; registered, held until the next completion
cout  out  1  add: decimal carry-out; sub: borrow-out (1 means a < b+cin)
invalid  out  1  at least one captured digit of a or b was greater than 9

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, invalid=0; internal registers cleared. Reset during RUN aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start.
  - RUN→DONE after DIGITS digit steps.
  - DONE→RUN if start is high; otherwise DONE→IDLE.
  - start is ignored in RUN.
- Capture at the start edge E0:
  - Latch a into an operand shift register.
  - Latch b into a second shift register. If mode=1, each b digit is replaced by 9−digit.
  - Carry register = cin if add; ~cin if sub.
  - Latch mode.
  - inv_r = OR over all 2*DIGITS raw digits of (digit > 9).
  - Digit counter = 0.
- Digit step, one per edge E0+1 … E0+DIGITS:
  - t = a_d + b_d + carry, 5 bits, range 0..19.
  - If t > 9: digit = (t+6)[3:0] and carry=1. Otherwise digit = t[3:0] and carry=0.
  - The result digit is shifted into the top of the result shift register; the operand registers shift right by 4.
- Completion: the edge that commits digit DIGITS−1 also loads the outputs and enters DONE.
  - sum = result register, or 0 if inv_r.
  - cout = final carry (add) or ~final carry (sub), forced to 0 if inv_r.
  - invalid = inv_r.
- done=1 exactly in the cycle after edge E0+DIGITS, i.e. a latency of DIGITS clocks from the start edge.
- busy=1 in cycles E0+1 … E0+DIGITS and is 0 in DONE.
- Subtract with borrow-out: sum is the ten's complement of (b+cin−a) modulo 10^DIGITS.
- With DIGITS=1 the block completes in one RUN cycle.
- Back-to-back operation: start during the DONE cycle gives done pulses DIGITS+1 cycles apart. sum/cout/invalid keep the previous values until the new completion.

Decomposition:
- Shared package bcd_pkg holds:
  - BCD_W=4 and BCD_MAX=9
  - state encodings ST_IDLE, ST_RUN, ST_DONE
  - mode encodings MODE_ADD=0, MODE_SUB=1
- One natural sub-module: bcd_digit_add, a combinational single-digit corrected adder (a_d, b_d, cin → digit, cout), instantiated once.
- The nine's complement is done inline at capture.

Test Plan:
1. DIGITS=4, add 0x1234+0x5678, cin=0 → sum=0x6912, cout=0, invalid=0; done is high exactly 4 cycles after the start edge, busy is high for 4 cycles.
2. Add 0x9999+0x0001, cin=0 → sum=0x0000, cout=1. Add 0x0999+0x0000, cin=1 → sum=0x1000, cout=0.
3. Sub 0x5000−0x1234, cin=0 → sum=0x3766, cout=0. Sub 0x1234−0x5000 → sum=0x6234, cout=1. Sub 0x0000−0x0000, cin=1 → sum=0x9999, cout=1.
4. a=0x12A4, b=0x0001 → invalid=1, sum=0, cout=0 after the normal 4-cycle latency; the next valid operation clears invalid.
5. Pulse start again in cycle 2 of RUN → ignored, result is unchanged. Assert rst_n=0 mid-RUN → all outputs 0 immediately, no done pulse, and the FSM accepts a new start afterward.
6. start held through DONE with new operands 0x0001+0x0001 → second done pulse 5 cycles after the first, sum=0x0002; sum holds the first result until then. Repeat with DIGITS=1: 9+9, cin=1 → sum=0x9, cout=1, latency 1.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants, FSM state and mode encodings for the digit-serial adder/subtractor.
package bcd_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic bcd_digit_bad(input logic [3:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit corrected BCD adder: a_d + b_d + cin with +6 correction above nine.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a_d,
  input  logic [3:0] b_d,
  input  logic       cin,
  output logic [3:0] digit,
  output logic       cout
);

  logic [4:0] t_s;

  // Raw binary digit sum followed by the decimal correction.
  always_comb begin
    t_s = {1'b0, a_d} + {1'b0, b_d} + {4'b0000, cin};
    if (t_s > {1'b0, BCD_MAX}) begin
      digit = t_s[3:0] + 4'd6;
      cout  = 1'b1;
    end else begin
      digit = t_s[3:0];
      cout  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_addsub_seq.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first,
// with start/busy/done handshake. Subtraction uses nine's complement of b.
module bcd_addsub_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  invalid
);

  localparam int W     = 4 * DIGITS;
  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_sr_q, a_sr_d;
  logic [W-1:0]     b_sr_q, b_sr_d;
  logic [W-1:0]     res_q, res_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic             inv_q, inv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             invalid_q, invalid_d;

  logic [W-1:0]     cap_b_s;
  logic             cap_inv_s;
  logic [3:0]       dig_s;
  logic             dig_cout_s;
  logic [W-1:0]     dig_ext_s;
  logic [W-1:0]     res_shift_s;

  bcd_digit_add u_digit (
    .a_d   (a_sr_q[3:0]),
    .b_d   (b_sr_q[3:0]),
    .cin   (carry_q),
    .digit (dig_s),
    .cout  (dig_cout_s)
  );

  // Capture-time view of b (nine's complemented for subtract) and the raw-digit validity flag.
  always_comb begin
    cap_b_s   = '0;
    cap_inv_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (mode == MODE_SUB) begin
        cap_b_s[4*i +: 4] = BCD_MAX - b[4*i +: 4];
      end else begin
        cap_b_s[4*i +: 4] = b[4*i +: 4];
      end
      cap_inv_s = cap_inv_s | bcd_digit_bad(a[4*i +: 4]) | bcd_digit_bad(b[4*i +: 4]);
    end
  end

  // New result digit enters at the top so digit 0 ends up in bits [3:0].
  always_comb begin
    dig_ext_s      = '0;
    dig_ext_s[3:0] = dig_s;
    res_shift_s    = (res_q >> BCD_W) | (dig_ext_s << (W - BCD_W));
  end

  // Next-state and datapath control for IDLE / RUN / DONE.
  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    res_d     = res_q;
    carry_d   = carry_q;
    mode_d    = mode_q;
    inv_d     = inv_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sum_d     = sum_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_sr_d  = a;
          b_sr_d  = cap_b_s;
          res_d   = '0;
          carry_d = (mode == MODE_SUB) ? ~cin : cin;
          mode_d  = mode;
          inv_d   = cap_inv_s;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        a_sr_d  = a_sr_q >> BCD_W;
        b_sr_d  = b_sr_q >> BCD_W;
        res_d   = res_shift_s;
        carry_d = dig_cout_s;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d   = ST_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          sum_d     = inv_q ? '0 : res_shift_s;
          // In subtract mode the adder carry is the inverse of the borrow.
          cout_d    = inv_q ? 1'b0 : ((mode_q == MODE_SUB) ? ~dig_cout_s : dig_cout_s);
          invalid_d = inv_q;
        end else begin
          state_d = ST_RUN;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      mode_q    <= MODE_ADD;
      inv_q     <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      res_q     <= res_d;
      carry_q   <= carry_d;
      mode_q    <= mode_d;
      inv_q     <= inv_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;

endmodule
